// File: rtl/temp_avg_accumulator.sv
// temp_avg_accumulator
// Collects 2^LOG2N signed samples over a valid/ready stream, sums them through
// a ripple chain of full-adder cells and presents the block sum and the
// floor-average until downstream takes the result.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. in_ready and out_valid are decoded from the
// state register alone, so neither depends combinationally on in_valid or
// out_ready, and out_sum/out_avg stay constant while out_valid is held.

// One-bit full-adder cell used to build the accumulator's ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module temp_avg_accumulator #(
   parameter int DATA_W = 8,
   parameter int LOG2N  = 2
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      clear,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_temp,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W+LOG2N-1:0]   out_sum,
   output logic [DATA_W-1:0]         out_avg,
   output logic [LOG2N-1:0]          sample_cnt,
   output logic                      state_dbg
);

   // Sum width: N samples of DATA_W bits never overflow DATA_W+LOG2N bits.
   localparam int SW = DATA_W + LOG2N;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     sum_q, sum_d;
   logic [LOG2N-1:0]  cnt_q, cnt_d;

   // Sign-extended sample fed into the adder chain.
   logic [SW-1:0]     addend;
   logic [SW-1:0]     sum_add;
   logic [SW-1:0]     carry;
   logic              unused_cout;

   assign addend   = {{LOG2N{in_temp[DATA_W-1]}}, in_temp};
   assign carry[0] = 1'b0;

   // Ripple chain: sum_add = sum_q + addend; the final carry is dropped
   // because the width already covers the full range of a block.
   for (genvar i = 0; i < SW; i++) begin : g_fa
      if (i < SW - 1) begin : g_mid
         full_adder u_fa (
            .a    (sum_q[i]),
            .b    (addend[i]),
            .cin  (carry[i]),
            .s    (sum_add[i]),
            .cout (carry[i+1])
         );
      end else begin : g_last
         full_adder u_fa (
            .a    (sum_q[i]),
            .b    (addend[i]),
            .cin  (carry[i]),
            .s    (sum_add[i]),
            .cout (unused_cout)
         );
      end
   end

   // State, sum and sample-count registers with asynchronous reset.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ACCUM;
         sum_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: clear beats everything, then accept or handshake.
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = ACCUM;
         sum_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (in_valid) begin
                  sum_d = sum_add;
                  cnt_d = cnt_q + LOG2N'(1);
                  if (cnt_q == {LOG2N{1'b1}}) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  sum_d   = '0;
                  state_d = ACCUM;
               end
            end
            default: begin
               state_d = ACCUM;
            end
         endcase
      end
   end

   assign in_ready   = (state_q == ACCUM);
   assign out_valid  = (state_q == HOLD);
   assign out_sum    = sum_q;
   // Arithmetic shift right by LOG2N keeping DATA_W bits is exactly the top
   // DATA_W bits of the sum, which gives floor(sum / N).
   assign out_avg    = sum_q[LOG2N +: DATA_W];
   assign sample_cnt = cnt_q;
   assign state_dbg  = state_q;

endmodule

// File: doc/temp_avg_accumulator.md
# temp_avg_accumulator

Collects a block of 2^LOG2N signed temperature samples over a valid/ready stream, accumulates them through a ripple chain of the team's full-adder cells, and presents the block sum and floor-average downstream. It sits between the sensor sampling front end and the temperature display/compare logic in the temperature calculator, and is the sequential stage that drives the full-adder chain.

## Interface

- DATA_W, 8, width of one signed two's-complement sample and of out_avg.
- LOG2N, 2, log2 of samples per block (N = 2^LOG2N); legal range 1..4.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- nrst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort of current block.
- in_valid  in  1  in_temp holds a sample.
- in_ready  out  1  block accepts a sample this cycle.
- in_temp  in  DATA_W  signed sample.
- out_valid  out  1  out_sum/out_avg hold a completed block.
- out_ready  in  1  downstream takes the result this cycle.
- out_sum  out  DATA_W+LOG2N  signed sum of the N samples.
- out_avg  out  DATA_W  signed floor(sum / N).
- sample_cnt  out  LOG2N  samples accepted in the current block.

## Operation

- Two states: ACCUM, HOLD. Reset state ACCUM.
- ACCUM: in_ready = 1. Accept when in_valid & in_ready: sum <= sum + sign-extended in_temp; sample_cnt <= sample_cnt + 1 (wraps).
- Accepting while sample_cnt = N-1: sum takes final value, sample_cnt wraps to 0, state -> HOLD.
- HOLD: in_ready = 0, out_valid = 1; in_valid ignored. When out_ready = 1: sum <= 0, state -> ACCUM.
- Adder: DATA_W+LOG2N-bit ripple chain of full-adder cells, carry-in 0; no overflow possible by width choice; final carry discarded.
- out_sum = sum register; out_avg = sum arithmetic-shifted right by LOG2N, low DATA_W bits (floor toward minus infinity; always representable).
- clear = 1 (any state): sum <= 0, sample_cnt <= 0, state -> ACCUM; an in_valid on the same cycle is discarded; priority over accept and out_ready.
- in_ready and out_valid are decoded from the state register only; no combinational path from in_valid or out_ready to any output.

## Timing

- Reset values: in_ready 1, out_valid 0, out_sum 0, out_avg 0, sample_cnt 0.
- Reset asserted mid-block or in HOLD: all registers clear immediately, partial block discarded; first edge after release may accept a sample.
- Latency: Nth sample accepted at edge k -> out_valid = 1 and result stable from edge k to the edge where out_ready = 1 is seen.
- Results are held unchanged while out_valid = 1 and out_ready = 0, indefinitely.
- Handshake at edge j with out_valid & out_ready: out_valid = 0, in_ready = 1 after j; next sample accepted no earlier than edge j+1.
- Maximum throughput: one block per N+1 cycles (N accepts + 1 HOLD cycle).
- in_valid gaps in ACCUM: sum and sample_cnt hold.
- out_ready asserted while in ACCUM: no effect.

## Test plan

- DATA_W=8, LOG2N=2, all scenarios; check reset values after every nrst pulse.
- Samples 20, 22, 24, 26 back-to-back, out_ready=1 -> out_sum 92, out_avg 23, out_valid for exactly 1 cycle, next block accepted on following edge.
- Samples -3, -4, -4, -4 -> out_sum -15 (10'h3F1), out_avg -4 (8'hFC), floor rounding confirmed.
- Extremes: four 127 -> out_sum 508, out_avg 127; four -128 -> out_sum -512 (10'h200), out_avg -128 (8'h80).
- Backpressure: complete block 10,10,10,10 with out_ready=0 for 5 cycles and in_valid=1 driving 99 -> out_sum 40/out_avg 10 stable, in_ready 0, 99 never accumulated; out_ready=1 -> out_valid falls next edge.
- Abort: accept 50, 60, then clear=1 with in_valid=1 -> sample_cnt 0; then 1, 2, 3, 6 -> out_sum 12, out_avg 3. Repeat with nrst pulse low after two samples and in HOLD -> same clean restart.
